dma_rd_master: RTL and testbench

DMA_RD_MASTER -- requirements
Module: dma_rd_master

---
 rtl/dma_rd_master_pkg.sv | 23 ++
 rtl/dma_rd_master_if.sv | 40 ++++
 rtl/sync_fifo.sv | 54 +++++
 rtl/dma_rd_master.sv | 155 +++++++++++++++
 tb/tb_dma_rd_master.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_rd_master_pkg.sv
// Shared types and constants for the DMA read master: FSM state encoding,
// AXI encodings and the 4KB boundary helper.
package dma_rd_master_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    ADDR,
    DATA,
    FLUSH
  } state_e;

  localparam logic [2:0]  AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;
  localparam int unsigned BOUNDARY_4K    = 4096;

  // Words left before the next 4KB boundary, given the low 12 bits of a word-aligned address.
  function automatic logic [31:0] words_to_4k(input logic [11:0] addr_lo);
    return (32'(BOUNDARY_4K) - 32'(addr_lo)) >> 2;
  endfunction

endpackage

// File: rtl/dma_rd_master_if.sv
// AXI4 read channels plus the output stream of the DMA read master.
// master: the DMA side; slave: memory/interconnect and stream sink side.
interface dma_rd_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] m_axi_araddr;
  logic [7:0]            m_axi_arlen;
  logic [2:0]            m_axi_arsize;
  logic [1:0]            m_axi_arburst;
  logic                  m_axi_arvalid;
  logic                  m_axi_arready;
  logic [DATA_WIDTH-1:0] m_axi_rdata;
  logic [1:0]            m_axi_rresp;
  logic                  m_axi_rlast;
  logic                  m_axi_rvalid;
  logic                  m_axi_rready;
  logic [31:0]           m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tlast;
  logic                  m_axis_tready;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready
  );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read and a free-entry count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned AW = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [AW:0]           o_free
);
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(FIFO_DEPTH));
  assign o_free    = (AW+1)'(FIFO_DEPTH) - r_count;
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_rdata   = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates the read side.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/dma_rd_master.sv
// DMA read master: fetches i_total_len bytes from i_base_addr over AXI4 INCR
// bursts (one outstanding) into a FIFO that drives an AXI-stream output.
// A burst is only requested once the FIFO has room for all of its beats, so
// R data is always accepted. Define DMA_RD_4K_SPLIT_EN to stop bursts from
// crossing 4KB address boundaries.
module dma_rd_master
  import dma_rd_master_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [31:0]           i_total_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  dma_rd_master_if.master       bus
);
  localparam int unsigned FAW = $clog2(FIFO_DEPTH);

  state_e                r_state;
  state_e                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_remaining;
  logic [4:0]            r_beats;
  logic                  r_error;
  logic [31:0]           w_beats_calc;
  logic                  w_credit_ok;
  logic                  w_r_hs;
  logic                  w_push;
  logic                  w_push_last;
  logic                  w_pop;
  logic [DATA_WIDTH:0]   w_fifo_rdata;
  logic                  w_fifo_empty;
  logic                  w_fifo_full;
  logic [FAW:0]          w_fifo_free;
  logic                  w_unused_bits;

  assign w_unused_bits = ^{i_total_len[1:0], i_base_addr[1:0], w_beats_calc[31:5], w_fifo_full};

  assign w_credit_ok = 32'(w_fifo_free) >= 32'(r_beats);
  assign w_r_hs      = bus.m_axi_rvalid && bus.m_axi_rready;
  assign w_push      = w_r_hs;
  // Last beat of the last burst carries the stream tlast flag through the FIFO.
  assign w_push_last = bus.m_axi_rlast && (r_remaining == 32'(r_beats));
  assign w_pop       = bus.m_axis_tvalid && bus.m_axis_tready;

  assign bus.m_axi_araddr  = r_addr;
  assign bus.m_axi_arlen   = {3'b000, r_beats - 5'd1};
  assign bus.m_axi_arsize  = AXI_SIZE_4B;
  assign bus.m_axi_arburst = AXI_BURST_INCR;
  assign bus.m_axis_tdata  = w_fifo_rdata[31:0];
  assign bus.m_axis_tvalid = !w_fifo_empty;
  assign bus.m_axis_tlast  = !w_fifo_empty && w_fifo_rdata[DATA_WIDTH];
  assign o_busy            = (r_state != IDLE);
  assign o_error           = r_error;

  // Burst length: remaining words capped by MAX_BURST and optionally the 4KB boundary.
  always_comb begin
    w_beats_calc = 32'(MAX_BURST);
    if (r_remaining < w_beats_calc) w_beats_calc = r_remaining;
`ifdef DMA_RD_4K_SPLIT_EN
    if (words_to_4k(r_addr[11:0]) < w_beats_calc) w_beats_calc = words_to_4k(r_addr[11:0]);
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next      = r_state;
    bus.m_axi_arvalid = 1'b0;
    bus.m_axi_rready  = 1'b0;
    o_done            = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start) w_state_next = (i_total_len[31:2] == '0) ? FLUSH : CALC;
      end
      CALC: w_state_next = ADDR;
      ADDR: begin
        bus.m_axi_arvalid = w_credit_ok;
        if (w_credit_ok && bus.m_axi_arready) w_state_next = DATA;
      end
      DATA: begin
        bus.m_axi_rready = 1'b1;
        if (bus.m_axi_rvalid && bus.m_axi_rlast) begin
          w_state_next = (r_remaining == 32'(r_beats)) ? FLUSH : CALC;
        end
      end
      FLUSH: begin
        if (w_fifo_empty) begin
          o_done       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Transfer bookkeeping: address, remaining words, burst size and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_beats     <= '0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_addr      <= {i_base_addr[ADDR_WIDTH-1:2], 2'b00};
            r_remaining <= {2'b00, i_total_len[31:2]};
            r_error     <= 1'b0;
          end
        end
        CALC: r_beats <= w_beats_calc[4:0];
        DATA: begin
          if (w_r_hs) begin
            if (bus.m_axi_rresp != AXI_RESP_OKAY) r_error <= 1'b1;
            if (bus.m_axi_rlast) begin
              r_addr      <= r_addr + ADDR_WIDTH'({r_beats, 2'b00});
              r_remaining <= r_remaining - 32'(r_beats);
            end
          end
        end
        default: ;
      endcase
    end
  end

  sync_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({w_push_last, bus.m_axi_rdata}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_free  (w_fifo_free)
  );

endmodule

// File: tb/tb_dma_rd_master.sv
// Bench for dma_rd_master: an AXI memory model plus stream sink, with expected
// stream words and AR requests queued at stimulus time and checked on handshake.
`timescale 1ns/1ps
module tb_dma_rd_master;
  localparam int unsigned FIFO_DEPTH = 32;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } word_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_base_addr = '0;
  logic [31:0] i_total_len = '0;
  logic        o_busy;
  logic        o_done;
  logic        o_error;

  dma_rd_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dma_rd_master #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .MAX_BURST  (16),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_base_addr (i_base_addr),
    .i_total_len (i_total_len),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  word_t exp_words[$];
  ar_t   exp_ars[$];

  // Memory / sink model state
  bit          rand_mode = 0;
  bit          tready_en = 0;
  int          err_beat = -1;
  bit          r_active = 0;
  logic [31:0] r_addr = '0;
  int          r_left = 0;
  int          beat_idx = 0;
  int          buffered = 0;
  int          ar_count = 0;
  int          arvalid_count = 0;
  int          tvalid_count = 0;
  int          stream_count = 0;
  bit          prev_stall = 0;
  logic [31:0] prev_tdata = '0;
  bit          prev_ar_wait = 0;
  ar_t         prev_ar;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model and stream sink; inputs change on the falling edge, the DUT samples on rising.
  initial begin
    int    buf_now;
    word_t w;
    ar_t   e;
    bus.m_axi_arready = 1'b0;
    bus.m_axi_rvalid  = 1'b0;
    bus.m_axi_rdata   = '0;
    bus.m_axi_rresp   = 2'b00;
    bus.m_axi_rlast   = 1'b0;
    bus.m_axis_tready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        r_active = 0; r_left = 0; buffered = 0; beat_idx = 0;
        prev_stall = 0; prev_ar_wait = 0;
        bus.m_axi_arready = 1'b0;
        bus.m_axi_rvalid  = 1'b0;
        bus.m_axi_rlast   = 1'b0;
        bus.m_axi_rresp   = 2'b00;
        bus.m_axis_tready = 1'b0;
        continue;
      end
      buf_now = buffered;

      // Stream sink
      bus.m_axis_tready = tready_en && (!rand_mode || ($urandom_range(0, 3) != 0));
      if (prev_stall) begin
        vectors++;
        if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== prev_tdata) begin
          miscompares++;
          $display("FAIL tdata_hold: tvalid=%b tdata=%h, required 1 %h",
                   bus.m_axis_tvalid, bus.m_axis_tdata, prev_tdata);
        end
      end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_tdata = bus.m_axis_tdata;
      if (bus.m_axis_tvalid) tvalid_count++;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        stream_count++;
        buffered--;
        vectors++;
        if (exp_words.size() == 0) begin
          miscompares++;
          $display("FAIL stream_extra: got %h, required no beat", bus.m_axis_tdata);
        end else begin
          w = exp_words.pop_front();
          if (bus.m_axis_tdata !== w.data || bus.m_axis_tlast !== w.last) begin
            miscompares++;
            $display("FAIL stream_word: got %h last=%b, required %h last=%b",
                     bus.m_axis_tdata, bus.m_axis_tlast, w.data, w.last);
          end
        end
      end

      // R channel
      if (r_active) begin
        bus.m_axi_rvalid = !rand_mode || ($urandom_range(0, 1) == 1);
        bus.m_axi_rdata  = mem_word(r_addr);
        bus.m_axi_rlast  = (r_left == 1);
        bus.m_axi_rresp  = (beat_idx == err_beat) ? 2'b10 : 2'b00;
        if (bus.m_axi_rvalid && bus.m_axi_rready) begin
          beat_idx++; buffered++; r_addr += 32'd4; r_left--;
          if (r_left == 0) r_active = 0;
          vectors++;
          if (buffered > FIFO_DEPTH) begin
            miscompares++;
            $display("FAIL fifo_bound: got %0d words buffered, required <= %0d",
                     buffered, FIFO_DEPTH);
          end
        end
      end else begin
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast  = 1'b0;
        bus.m_axi_rresp  = 2'b00;
      end

      // AR channel
      if (prev_ar_wait) begin
        vectors++;
        if (bus.m_axi_arvalid !== 1'b1 || bus.m_axi_araddr !== prev_ar.addr ||
            bus.m_axi_arlen !== prev_ar.len) begin
          miscompares++;
          $display("FAIL ar_hold: got v=%b %h/%0d, required v=1 %h/%0d", bus.m_axi_arvalid,
                   bus.m_axi_araddr, bus.m_axi_arlen, prev_ar.addr, prev_ar.len);
        end
      end
      bus.m_axi_arready = !rand_mode || ($urandom_range(0, 2) != 0);
      prev_ar_wait = bus.m_axi_arvalid && !bus.m_axi_arready;
      prev_ar.addr = bus.m_axi_araddr;
      prev_ar.len  = bus.m_axi_arlen;
      if (bus.m_axi_arvalid) begin
        arvalid_count++;
        vectors++;
        if (buf_now + int'(bus.m_axi_arlen) + 1 > FIFO_DEPTH) begin
          miscompares++;
          $display("FAIL ar_credit: got %0d buffered + %0d beats, required <= %0d",
                   buf_now, int'(bus.m_axi_arlen) + 1, FIFO_DEPTH);
        end
        if (bus.m_axi_arready) begin
          ar_count++;
          vectors++;
          if (exp_ars.size() == 0) begin
            miscompares++;
            $display("FAIL ar_extra: got %h/%0d, required no AR",
                     bus.m_axi_araddr, bus.m_axi_arlen);
          end else begin
            e = exp_ars.pop_front();
            if (bus.m_axi_araddr !== e.addr || bus.m_axi_arlen !== e.len ||
                bus.m_axi_arsize !== 3'b010 || bus.m_axi_arburst !== 2'b01 || r_active) begin
              miscompares++;
              $display("FAIL ar_req: got %h len=%0d size=%b burst=%b busy=%b, required %h len=%0d size=010 burst=01 busy=0",
                       bus.m_axi_araddr, bus.m_axi_arlen, bus.m_axi_arsize,
                       bus.m_axi_arburst, r_active, e.addr, e.len);
            end
          end
          r_active = 1;
          r_addr   = bus.m_axi_araddr;
          r_left   = int'(bus.m_axi_arlen) + 1;
        end
      end
    end
  end

  task automatic push_ar(input logic [31:0] addr, input logic [7:0] len);
    ar_t a;
    a.addr = addr;
    a.len  = len;
    exp_ars.push_back(a);
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [31:0] len);
    word_t       w;
    logic [31:0] ab;
    int          n;
    ab = {base[31:2], 2'b00};
    n  = int'(len >> 2);
    for (int i = 0; i < n; i++) begin
      w.data = mem_word(ab + 32'(4 * i));
      w.last = (i == n - 1);
      exp_words.push_back(w);
    end
    beat_idx = 0;
    @(negedge clk);
    i_base_addr = base;
    i_total_len = len;
    i_start     = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    while (o_done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (o_done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_done: got no o_done in %0d cycles, required a pulse", name, budget);
    end
    vectors++;
    if (exp_words.size() != 0 || exp_ars.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d words %0d ARs pending, required 0 0",
               name, exp_words.size(), exp_ars.size());
    end
    @(negedge clk);
    vectors++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: got done=%b busy=%b, required 0 0", name, o_done, o_busy);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    logic [6:0] got;
    got = {bus.m_axi_arvalid, bus.m_axi_rready, bus.m_axis_tvalid, bus.m_axis_tlast,
           o_busy, o_done, o_error};
    vectors++;
    if (got !== 7'b0) begin
      miscompares++;
      $display("FAIL %s: got arv/rrdy/tv/tl/busy/done/err=%b, required 0000000", name, got);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_burst();
    int ar0 = ar_count;
    int s0 = stream_count;
    rand_mode = 0; tready_en = 1;
    push_ar(32'h1000, 8'd15);
    start_xfer(32'h1000, 32'd64);
    wait_done(200, "single");
    vectors++;
    if (ar_count - ar0 != 1 || stream_count - s0 != 16) begin
      miscompares++;
      $display("FAIL single_counts: got %0d ARs %0d beats, required 1 16",
               ar_count - ar0, stream_count - s0);
    end
  endtask

  task automatic test_4k_split();
`ifdef DMA_RD_4K_SPLIT_EN
    push_ar(32'h0FF8, 8'd1);
    push_ar(32'h1000, 8'd5);
`else
    push_ar(32'h0FF8, 8'd7);
`endif
    start_xfer(32'h0FF8, 32'd32);
    wait_done(200, "split");
  endtask

  task automatic test_zero_len();
    int av0 = arvalid_count;
    int tv0 = tvalid_count;
    start_xfer(32'h1234, 32'd0);
    wait_done(2, "zero");
    vectors++;
    if (arvalid_count != av0 || tvalid_count != tv0) begin
      miscompares++;
      $display("FAIL zero_quiet: got %0d arvalid %0d tvalid cycles, required 0 0",
               arvalid_count - av0, tvalid_count - tv0);
    end
  endtask

  task automatic test_backpressure();
    int ar0 = ar_count;
    int s0 = stream_count;
    tready_en = 0;
    for (int i = 0; i < 4; i++) push_ar(32'h2000 + 32'(64 * i), 8'd15);
    start_xfer(32'h2000, 32'd256);
    repeat (100) @(negedge clk);
    vectors++;
    if (ar_count - ar0 != 2 || stream_count - s0 != 0 || bus.m_axis_tvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_state: got %0d ARs %0d beats tvalid=%b, required 2 0 1",
               ar_count - ar0, stream_count - s0, bus.m_axis_tvalid);
    end
    tready_en = 1;
    wait_done(500, "stall");
    vectors++;
    if (stream_count - s0 != 64) begin
      miscompares++;
      $display("FAIL stall_beats: got %0d, required 64", stream_count - s0);
    end
  endtask

  task automatic test_error();
    err_beat = 2;
    push_ar(32'h4000, 8'd15);
    start_xfer(32'h4000, 32'd64);
    repeat (12) @(negedge clk);
    vectors++;
    if (o_error !== 1'b1) begin
      miscompares++;
      $display("FAIL error_set: got %b, required 1", o_error);
    end
    wait_done(200, "error");
    vectors++;
    if (o_error !== 1'b1) begin
      miscompares++;
      $display("FAIL error_sticky: got %b, required 1", o_error);
    end
    err_beat = -1;
  endtask

  task automatic test_back_to_back();
    rand_mode = 1;
    push_ar(32'h5004, 8'd15);
    push_ar(32'h5044, 8'd0);
    start_xfer(32'h5006, 32'd70);
    vectors++;
    if (o_error !== 1'b0) begin
      miscompares++;
      $display("FAIL error_clear: got %b, required 0", o_error);
    end
    // A start while busy must be ignored.
    repeat (5) @(negedge clk);
    i_base_addr = 32'h9000; i_total_len = 32'd8; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    wait_done(2000, "b2b_a");
`ifdef DMA_RD_4K_SPLIT_EN
    push_ar(32'h0FF0, 8'd3);
    push_ar(32'h1000, 8'd7);
`else
    push_ar(32'h0FF0, 8'd11);
`endif
    start_xfer(32'h0FF0, 32'd48);
    wait_done(2000, "b2b_b");
    rand_mode = 0;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int s0;
    push_ar(32'h3000, 8'd15);
    start_xfer(32'h3000, 32'd64);
    while (beat_idx < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    exp_words.delete();
    exp_ars.delete();
    @(negedge clk);
    check_reset_outputs("reset_mid");
    rst = 1'b0;
    @(negedge clk);
    s0 = stream_count;
    push_ar(32'h0000, 8'd3);
    start_xfer(32'h0000, 32'd16);
    wait_done(200, "after_rst");
    vectors++;
    if (stream_count - s0 != 4) begin
      miscompares++;
      $display("FAIL after_rst_beats: got %0d, required 4", stream_count - s0);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_4k_split();
    test_zero_len();
    test_backpressure();
    test_error();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
